// File: rtl/sound_sequencer.sv
// Plays short square-wave jingles from a fixed note ROM.
// Each sound is a list of (tone, duration) notes, separated by silent gaps.
module sound_sequencer #(
  parameter int CLK_HZ   = 100000000,
  parameter int GAP_MS   = 10,
  parameter int MIN_FREQ = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] soundType,
  input  logic       play,
  input  logic       stop,
  output logic       audio,
  output logic       busy,
  output logic       done
);

  localparam int TICK     = CLK_HZ / 1000;
  localparam int TW       = $clog2(CLK_HZ / (2 * MIN_FREQ) + 1);
  localparam int LONG_CYC = ((GAP_MS > 300) ? GAP_MS : 300) * TICK;
  localparam int CW       = $clog2(LONG_CYC + 1);
  localparam logic [CW-1:0] GAP_LEN = CW'(GAP_MS * TICK);

  typedef enum logic [1:0] {IDLE, NOTE, GAP, DONE} state_t;

  // Half-period of the tone, in clocks, for note i of sound t.
  function automatic logic [TW-1:0] note_half(input logic [1:0] t, input logic [1:0] i);
    case ({t, i})
      4'b01_00: note_half = TW'(CLK_HZ / (2 * 880));
      4'b10_00: note_half = TW'(CLK_HZ / (2 * 440));
      4'b10_01: note_half = TW'(CLK_HZ / (2 * 523));
      4'b10_10: note_half = TW'(CLK_HZ / (2 * 659));
      4'b11_00: note_half = TW'(CLK_HZ / (2 * 523));
      4'b11_01: note_half = TW'(CLK_HZ / (2 * 659));
      4'b11_10: note_half = TW'(CLK_HZ / (2 * 784));
      4'b11_11: note_half = TW'(CLK_HZ / (2 * 1047));
      default:  note_half = '1;
    endcase
  endfunction

  // Note length in clocks for note i of sound t.
  function automatic logic [CW-1:0] note_len(input logic [1:0] t, input logic [1:0] i);
    case ({t, i})
      4'b01_00: note_len = CW'(50 * TICK);
      4'b10_00,
      4'b10_01,
      4'b10_10: note_len = CW'(100 * TICK);
      4'b11_00,
      4'b11_01,
      4'b11_10: note_len = CW'(150 * TICK);
      4'b11_11: note_len = CW'(300 * TICK);
      default:  note_len = CW'(1);
    endcase
  endfunction

  function automatic logic [1:0] last_idx(input logic [1:0] t);
    case (t)
      2'd2:    last_idx = 2'd2;
      2'd3:    last_idx = 2'd3;
      default: last_idx = 2'd0;
    endcase
  endfunction

  state_t         state;
  logic [1:0]     snd;
  logic [1:0]     idx;
  logic [TW-1:0]  tone_cnt;
  logic [CW-1:0]  len_cnt;
  logic [TW-1:0]  cur_half;
  logic [CW-1:0]  cur_len;

  assign cur_half = note_half(snd, idx);
  assign cur_len  = note_len(snd, idx);

  // stop (or play of "none" while playing) beats any start; a valid play
  // restarts from note 0 in every state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      snd      <= 2'd0;
      idx      <= 2'd0;
      tone_cnt <= '0;
      len_cnt  <= '0;
      audio    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop || (play && soundType == 2'd0 && busy)) begin
        state    <= IDLE;
        snd      <= 2'd0;
        idx      <= 2'd0;
        tone_cnt <= '0;
        len_cnt  <= '0;
        audio    <= 1'b0;
        busy     <= 1'b0;
      end else if (play && soundType != 2'd0) begin
        state    <= NOTE;
        snd      <= soundType;
        idx      <= 2'd0;
        tone_cnt <= '0;
        len_cnt  <= '0;
        audio    <= 1'b0;
        busy     <= 1'b1;
      end else begin
        case (state)
          NOTE: begin
            if (len_cnt == cur_len - CW'(1)) begin
              len_cnt  <= '0;
              tone_cnt <= '0;
              audio    <= 1'b0;
              if (idx == last_idx(snd)) begin
                state <= DONE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state <= GAP;
              end
            end else begin
              len_cnt <= len_cnt + CW'(1);
              if (tone_cnt == cur_half - TW'(1)) begin
                tone_cnt <= '0;
                audio    <= ~audio;
              end else begin
                tone_cnt <= tone_cnt + TW'(1);
              end
            end
          end
          GAP: begin
            audio <= 1'b0;
            if (len_cnt == GAP_LEN - CW'(1)) begin
              len_cnt <= '0;
              idx     <= idx + 2'd1;
              state   <= NOTE;
            end else begin
              len_cnt <= len_cnt + CW'(1);
            end
          end
          DONE: begin
            state <= IDLE;
            audio <= 1'b0;
          end
          default: begin
            state <= IDLE;
            audio <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/sound_sequencer.md
SOUND_SEQUENCER -- requirements
Module: sound_sequencer

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, meaning input clock frequency in Hz.
REQ-002 SHALL have parameter GAP_MS, default 10, meaning silent gap between consecutive notes in ms.
REQ-003 SHALL have parameter MIN_FREQ, default 100, meaning lowest supported tone in Hz; it sizes the tone counter.
REQ-004 SHALL have port clk, input, 1 bit, meaning the single rising-edge clock.
REQ-005 SHALL have port rst, input, 1 bit, meaning asynchronous active-low reset (0 = reset).
REQ-006 SHALL have port soundType, input, 2 bits, meaning sound select: 0 = none, 1 = click, 2 = point, 3 = win.
REQ-007 SHALL have port play, input, 1 bit, meaning start request, sampled each clock.
REQ-008 SHALL have port stop, input, 1 bit, meaning abort request, sampled each clock.
REQ-009 SHALL have port audio, output, 1 bit, meaning square-wave speaker drive.
REQ-010 SHALL have port busy, output, 1 bit, meaning a sequence is playing.
REQ-011 SHALL have port done, output, 1 bit, meaning one-cycle pulse when a sequence completes naturally.

Function
REQ-012 SHALL derive TICK = CLK_HZ/1000 cycles per ms, and HALF(f) = CLK_HZ/(2*f) with integer truncation, all at elaboration.
REQ-013 SHALL size the tone counter as clog2(CLK_HZ/(2*MIN_FREQ)+1) bits.
REQ-014 SHALL hold a fixed note ROM of (freq Hz, duration ms) entries, with at most 4 notes per sound:
  - click = (880,50).
  - point = (440,100), (523,100), (659,100).
  - win = (523,150), (659,150), (784,150), (1047,300).
REQ-015 SHALL implement states IDLE, NOTE, GAP and DONE.
REQ-016 SHALL accept play=1 with stop=0 and soundType!=0 in IDLE, DONE, NOTE or GAP at edge N:
  - latch soundType;
  - note index = 0;
  - enter NOTE at edge N;
  - busy=1 and audio=0 from edge N.
REQ-017 SHALL, while in NOTE, toggle audio every HALF(f) clocks: first toggle at HALF(f) cycles after note entry; tone counter restarts at every note entry.
REQ-018 SHALL keep each note in NOTE for exactly duration*TICK cycles.
REQ-019 SHALL, at the end of a non-last note, enter GAP for exactly GAP_MS*TICK cycles with audio=0, then start the next note per REQ-017.
REQ-020 SHALL, at the end of the last note, enter DONE with no gap: audio=0, busy=0 and done=1 for exactly one cycle, then go to IDLE.
REQ-021 SHALL treat play during NOTE or GAP as a restart from note 0 of the newly latched soundType, with no done pulse for the aborted sequence.
REQ-022 SHALL treat play with soundType=0 as a no-op in IDLE, and as a stop when busy.
REQ-023 SHALL, on stop=1, go to IDLE at that edge with audio=0 and busy=0 and no done pulse; stop wins over a simultaneous play.
REQ-024 SHALL keep audio=0 in IDLE, GAP and DONE, and never leave audio high after a sequence ends.

Reset
REQ-025 SHALL, while rst=0, asynchronously force state=IDLE, audio=0, busy=0, done=0, with all counters, the note index and the latched type cleared.
REQ-026 SHALL, on reset mid-sequence, discard the sequence; after release, no output changes until a new play is accepted.

Verification (CLK_HZ=1000000, GAP_MS=10; TICK=1000)
REQ-027 SHALL check: click play pulse -> audio toggles every 568 cycles for 50000 cycles, then done=1 for 1 cycle and busy falls with it.
REQ-028 SHALL check: point play -> notes of 1136, 956 and 758 half-periods, each 100000 cycles long, separated by 10000-cycle audio=0 gaps; total busy = 320000 cycles.
REQ-029 SHALL check: win play, then stop at cycle 200000 -> audio=0, busy=0 next edge, no done pulse.
REQ-030 SHALL check: during point note 2, play with soundType=3 -> restart with half-period 956 (523 Hz) from note 0, audio=0 at the restart edge, and a single done only after the win sequence ends.
REQ-031 SHALL check: play with soundType=0 in IDLE -> busy stays 0; play and stop in the same cycle -> IDLE.
REQ-032 SHALL check: rst=0 asserted mid-note between clock edges -> audio, busy and done drop to 0 immediately; after release, idle until the next play.
